clock_counter: RTL

- Timekeeping core of the digital clock; sits directly upstream of the seven-segment display stage.
- Produces packed-BCD hour/minute/second and the 2-bit function number shown on the leftmost digit.
- Internal prescaler divides CP down to a 1 s tick.
- MODE/ADJ key pulses drive a run/set state machine for time adjustment.

---
 rtl/clock_counter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/clock_counter.sv
// rtl/clock_counter.sv - BCD hh:mm:ss timekeeper with 1 s prescaler and run/set FSM
// Optional CLOCK_12H_EN: 12-hour hour sequence 12,01..11 with PM output.
module clock_counter #(
    parameter int DIV = 1000,
    parameter int PW  = 10
) (
    input  logic       CP,
    input  logic       RST,
    input  logic       MODE,
    input  logic       ADJ,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic [1:0] NUM,
    output logic       tick
`ifdef CLOCK_12H_EN
    ,
    output logic       PM
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
`ifdef CLOCK_12H_EN
    localparam logic [7:0] HOUR_RST = 8'h12;
`else
    localparam logic [7:0] HOUR_RST = 8'h00;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_nxt;
    logic          do_tick;
    logic          adj_h;
    logic          adj_m;
    logic          adj_s;

    // Packed-BCD increment that wraps to 00 once v reaches lim.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        logic [7:0] r;
        if (v == lim)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] hour_inc(input logic [7:0] h);
`ifdef CLOCK_12H_EN
        return (h == 8'h12) ? 8'h01 : bcd_inc(h, 8'h99);
`else
        return bcd_inc(h, 8'h23);
`endif
    endfunction

    always_ff @(posedge CP) begin
        if (RST)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_tick   = 1'b0;
        adj_h     = 1'b0;
        adj_m     = 1'b0;
        adj_s     = 1'b0;
        pre_nxt   = '0;
        if (MODE) begin
            case (state)
                RUN:     state_nxt = SET_H;
                SET_H:   state_nxt = SET_M;
                SET_M:   state_nxt = SET_S;
                default: state_nxt = RUN;
            endcase
        end
        // A tick on the last prescaler count still fires when MODE leaves RUN.
        do_tick = (state == RUN) && (pre == LAST);
        adj_h   = ADJ && !MODE && (state == SET_H);
        adj_m   = ADJ && !MODE && (state == SET_M);
        adj_s   = ADJ && !MODE && (state == SET_S);
        if ((state == RUN) && !MODE && (pre != LAST))
            pre_nxt = pre + PW'(1);
    end

    always_ff @(posedge CP) begin
        if (RST) begin
            pre    <= '0;
            tick   <= 1'b0;
            hour   <= HOUR_RST;
            minute <= 8'h00;
            second <= 8'h00;
`ifdef CLOCK_12H_EN
            PM     <= 1'b0;
`endif
        end else begin
            pre  <= pre_nxt;
            tick <= do_tick;
            if (do_tick) begin
                second <= bcd_inc(second, 8'h59);
                if (second == 8'h59) begin
                    minute <= bcd_inc(minute, 8'h59);
                    if (minute == 8'h59) begin
                        hour <= hour_inc(hour);
`ifdef CLOCK_12H_EN
                        if (hour == 8'h11)
                            PM <= ~PM;
`endif
                    end
                end
            end
            if (adj_h) begin
                hour <= hour_inc(hour);
`ifdef CLOCK_12H_EN
                if (hour == 8'h11)
                    PM <= ~PM;
`endif
            end
            if (adj_m)
                minute <= bcd_inc(minute, 8'h59);
            if (adj_s)
                second <= 8'h00;
        end
    end

    assign NUM = state;

endmodule
